// File: rtl/tlc5620_rx.sv
// Receive-side decoder for the TLC5620 serial DAC link: oversamples the driver's
// pins and rebuilds the DAC's input latches and output registers in fabric.

module tlc5620_rx_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s
);
    logic [STAGES-1:0] pipe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pipe <= {STAGES{RST_VAL}};
        else      pipe <= {pipe[STAGES-2:0], d};
    end

    assign s = pipe[STAGES-1];
endmodule

module tlc5620_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dac_clk,
    input  logic       data,
    input  logic       load,
    input  logic       ldac,
    output logic [7:0] ch_a,
    output logic [7:0] ch_b,
    output logic [7:0] ch_c,
    output logic [7:0] ch_d,
    output logic [3:0] rng,
    output logic       upd,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] last_addr
);
    localparam int         NUM_PINS = 4;
    localparam int         NUM_CH   = 4;
    // Pin order {ldac, load, data, dac_clk}; idle levels so reset release is edge-free.
    localparam logic [3:0] PIN_RST  = 4'b1100;

    logic [NUM_PINS-1:0] pin_raw, pin_s, pin_h;
    logic [2:0]          fall_q;
    logic                clk_fall, load_fall, ldac_fall;
    logic                load_s, ldac_s, data_d;

    assign pin_raw = {ldac, load, data, dac_clk};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PINS; gi++) begin : g_sync
            tlc5620_rx_sync #(
                .STAGES (SYNC_STAGES),
                .RST_VAL(PIN_RST[gi])
            ) u_sync (
                .clk(clk),
                .rst(rst),
                .d  (pin_raw[gi]),
                .s  (pin_s[gi])
            );
        end
    endgenerate

    // Edge pulses are registered so every pin event lands SYNC_STAGES+2 edges after the pin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pin_h  <= PIN_RST;
            fall_q <= '0;
        end else begin
            pin_h  <= pin_s;
            fall_q <= {pin_h[3] & ~pin_s[3], pin_h[2] & ~pin_s[2], pin_h[0] & ~pin_s[0]};
        end
    end

    assign clk_fall  = fall_q[0];
    assign load_fall = fall_q[1];
    assign ldac_fall = fall_q[2];
    assign load_s    = pin_s[2];
    assign ldac_s    = pin_s[3];
    // Data history bit lines up with the registered dac_clk fall, well inside the hold window.
    assign data_d    = pin_h[1];

    logic [10:0]              shift;
    logic [3:0]               bitcnt;
    logic [NUM_CH-1:0][8:0]   in_latch, out_reg;
    logic [NUM_CH-1:0][8:0]   lat_nxt, out_nxt;
    logic                     accept, imm_wr, shift_en;
    logic [1:0]               addr;
    logic [8:0]               word;

    assign addr     = shift[10:9];
    assign word     = shift[8:0];
    assign accept   = load_fall && (bitcnt >= 4'd11);
    assign imm_wr   = accept && !ldac_s;
    assign shift_en = clk_fall && load_s;

    always_comb begin
        lat_nxt = in_latch;
        if (accept) lat_nxt[addr] = word;
    end

    // ldac transfers the already-updated latches, so a coincident frame wins its channel.
    always_comb begin
        out_nxt = out_reg;
        if (ldac_fall)   out_nxt = lat_nxt;
        else if (imm_wr) out_nxt[addr] = word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift     <= '0;
            bitcnt    <= '0;
            in_latch  <= '0;
            out_reg   <= '0;
            last_addr <= '0;
            upd       <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (shift_en) shift <= {shift[9:0], data_d};

            if (load_fall)                      bitcnt <= '0;
            else if (shift_en && bitcnt != 4'hf) bitcnt <= bitcnt + 4'd1;

            in_latch <= lat_nxt;
            out_reg  <= out_nxt;
            if (accept) last_addr <= addr;

            frame_ok  <= accept;
            frame_err <= load_fall && !accept;
            upd       <= ldac_fall || imm_wr;
        end
    end

    assign ch_a = out_reg[0][7:0];
    assign ch_b = out_reg[1][7:0];
    assign ch_c = out_reg[2][7:0];
    assign ch_d = out_reg[3][7:0];

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_rng
            assign rng[gi] = out_reg[gi][8];
        end
    endgenerate
endmodule

// File: tb/tb_tlc5620_rx.sv
// Bench for tlc5620_rx: pin-level stimulus, frame-level reference model, event scoreboard.

module tb_tlc5620_rx;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dac_clk = 1'b0, data = 1'b0, load = 1'b1, ldac = 1'b1;
    logic [7:0] ch_a, ch_b, ch_c, ch_d;
    logic [3:0] rng;
    logic       upd, frame_ok, frame_err;
    logic [1:0] last_addr;

    always #5 clk = ~clk;

    tlc5620_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst_n), .dac_clk(dac_clk), .data(data), .load(load), .ldac(ldac),
        .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .ch_d(ch_d), .rng(rng),
        .upd(upd), .frame_ok(frame_ok), .frame_err(frame_err), .last_addr(last_addr)
    );

    typedef struct packed {
        logic            ok;
        logic            err;
        logic            upd;
        logic [1:0]      la;
        logic [3:0]      rng;
        logic [3:0][7:0] ch;
    } ev_t;

    ev_t  exp_q[$];
    int   tests = 0, fails = 0;
    logic [8:0] m_lat[4], m_out[4];
    logic [1:0] m_last;
    bit   m_bits[$];
    bit   ldac_low;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ev_t snap(input bit ok, input bit err, input bit u);
        ev_t e;
        e.ok = ok; e.err = err; e.upd = u; e.la = m_last;
        for (int n = 0; n < 4; n++) begin
            e.ch[n]  = m_out[n][7:0];
            e.rng[n] = m_out[n][8];
        end
        return e;
    endfunction

    function automatic logic [31:0] fr(input logic [1:0] a, input logic r, input logic [7:0] d);
        return 32'({a, r, d});
    endfunction

    always @(negedge clk) begin
        if (rst_n && (upd || frame_ok || frame_err)) begin
            ev_t a;
            a.ok = frame_ok; a.err = frame_err; a.upd = upd; a.la = last_addr;
            a.rng = rng; a.ch = {ch_d, ch_c, ch_b, ch_a};
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_event: got %h expected none", a);
            end else begin
                check("event", 64'(a), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_clear();
        for (int n = 0; n < 4; n++) begin m_lat[n] = '0; m_out[n] = '0; end
        m_last = '0; m_bits.delete(); ldac_low = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            data = v[i]; hold(H);
            dac_clk = 1'b1; hold(H);
            dac_clk = 1'b0; m_bits.push_back(v[i]); hold(H);
        end
    endtask

    task automatic load_pulse(input bit sim);
        bit acc;
        logic [10:0] f;
        load = 1'b0;
        if (sim) ldac = 1'b0;
        acc = (m_bits.size() >= 11);
        f = '0;
        if (acc) begin
            for (int k = 0; k < 11; k++) f[10-k] = m_bits[m_bits.size() - 11 + k];
            m_lat[f[10:9]] = f[8:0];
            m_last = f[10:9];
            if (ldac_low && !sim) m_out[f[10:9]] = f[8:0];
        end
        if (sim) for (int n = 0; n < 4; n++) m_out[n] = m_lat[n];
        m_bits.delete();
        exp_q.push_back(snap(acc, !acc, sim || (acc && ldac_low)));
        hold(H); load = 1'b1; hold(H);
        if (sim) begin ldac = 1'b1; hold(H); end
    endtask

    task automatic ldac_fall_t();
        ldac = 1'b0; ldac_low = 1'b1;
        for (int n = 0; n < 4; n++) m_out[n] = m_lat[n];
        exp_q.push_back(snap(1'b0, 1'b0, 1'b1));
    endtask

    task automatic ldac_rise_t();
        ldac = 1'b1; ldac_low = 1'b0; hold(H);
    endtask

    task automatic check_zero(input string name);
        check(name, 64'({ch_a, ch_b, ch_c, ch_d, rng, upd, frame_ok, frame_err, last_addr}), 64'd0);
    endtask

    task automatic reset_mid();
        #2 rst_n = 1'b0;
        model_clear();
        dac_clk = 1'b0; load = 1'b1; ldac = 1'b1; data = 1'b0;
        hold(3);
        check_zero("reset_mid_outs");
        rst_n = 1'b1; hold(H);
    endtask

    initial begin
        model_clear();
        rst_n = 1'b0; dac_clk = 1'b1; load = 1'b0; ldac = 1'b0;
        hold(5);
        check_zero("reset_outs");
        dac_clk = 1'b0; load = 1'b1; ldac = 1'b1;
        hold(2);
        rst_n = 1'b1;
        hold(10);
        send_bits(32'h2a5, 10);
        load_pulse(1'b0);

        // latched update, with ldac-to-upd latency probe
        send_bits(fr(2'd2, 1'b1, 8'h5a), 11);
        load_pulse(1'b0);
        ldac_fall_t();
        repeat (3) @(posedge clk);
        #1 check("upd_latency3", 64'(upd), 64'd0);
        @(posedge clk);
        #1 check("upd_latency4", 64'(upd), 64'd1);
        check("ch_c_latched", 64'(ch_c), 64'h5a);
        check("rng_latched", 64'(rng), 64'h4);
        hold(H);
        ldac_rise_t();

        // immediate update
        ldac_fall_t(); hold(H);
        send_bits(fr(2'd1, 1'b0, 8'hc3), 11);
        load_pulse(1'b0);
        ldac_rise_t();

        // short and long frames
        send_bits(32'h1ff, 9);
        load_pulse(1'b0);
        send_bits({19'd0, 2'b10, 11'(fr(2'd0, 1'b1, 8'hff))}, 13);
        load_pulse(1'b0);
        ldac_fall_t(); hold(H);
        ldac_rise_t();
        check("ch_a_long", 64'(ch_a), 64'hff);

        // coincident load and ldac
        send_bits(fr(2'd0, 1'b0, 8'h11), 11); load_pulse(1'b0);
        send_bits(fr(2'd1, 1'b0, 8'h22), 11); load_pulse(1'b0);
        send_bits(fr(2'd0, 1'b0, 8'h77), 11); load_pulse(1'b1);
        check("sim_ch_a", 64'(ch_a), 64'h77);
        check("sim_ch_b", 64'(ch_b), 64'h22);

        // reset mid-frame
        send_bits(32'h2d, 6);
        reset_mid();
        ldac_fall_t(); hold(H);
        send_bits(fr(2'd3, 1'b0, 8'h81), 11);
        load_pulse(1'b0);
        ldac_rise_t();
        check("ch_d_after_reset", 64'(ch_d), 64'h81);

        for (int it = 0; it < 40; it++) begin
            int n, mode;
            n = $urandom_range(8, 17);
            mode = $urandom_range(0, 3);
            case (mode)
                0: begin send_bits($urandom, n); load_pulse(1'b0); end
                1: begin send_bits($urandom, n); load_pulse(1'b1); end
                2: begin
                    ldac_fall_t(); hold(H);
                    send_bits($urandom, n); load_pulse(1'b0);
                    ldac_rise_t();
                end
                default: begin
                    send_bits($urandom, n); load_pulse(1'b0);
                    ldac_fall_t(); hold(H);
                    ldac_rise_t();
                end
            endcase
        end

        hold(20);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tlc5620_rx.md
# tlc5620_rx

Receive-side decoder for the TLC5620 4-channel DAC serial interface. It samples the dac_clk/data/load/ldac lines that the DAC driver produces and rebuilds the DAC's internal state: four input latches, four output registers and their range bits. It is the in-fabric twin of the DAC: the self-check path and the display path read back the codes that were sent instead of the codes that were intended. It runs on the system clock and oversamples the serial lines.

## Interface
- SYNC_STAGES, 2: synchronizer flip-flops per serial input (legal values 2..3).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- dac_clk  in  1  serial clock from the DAC driver; data is captured on its falling edge.
- data  in  1  serial data, MSB first.
- load  in  1  frame latch strobe, active-low.
- ldac  in  1  output update strobe, active-low.
- ch_a, ch_b, ch_c, ch_d  out  8 each  DAC output register codes.
- rng  out  4  output-register range bits; bit n belongs to channel n (A=0).
- upd  out  1  one-cycle pulse when any output register is written.
- frame_ok  out  1  one-cycle pulse when a frame is accepted.
- frame_err  out  1  one-cycle pulse when a frame is rejected (short frame).
- last_addr  out  2  address of the last accepted frame.

## Operation
- Every serial input passes through SYNC_STAGES flip-flops, then one history flip-flop. An edge is detected when the history bit differs from the synchronized bit.
- Synchronizer reset values: dac_clk=0, data=0, load=1, ldac=1. With these values, reset release produces no spurious edges.
- Frame format: 11 bits, in order A1 A0 RNG D7..D0.
- shift[10:0] takes {shift[9:0], data_s} on each dac_clk falling edge, but only while load_s=1. While load_s=0, dac_clk edges are ignored.
- bitcnt is 4 bits. It increments on each accepted shift and saturates at 15.
- On each load falling edge:
  - If bitcnt >= 11, the frame is accepted:
    - in_latch[A] <= {RNG, D}, using the last 11 bits shifted.
    - last_addr <= A.
    - frame_ok pulses.
    - If ldac_s=0 in the same cycle, out_reg[A] <= {RNG, D} and upd pulses.
  - If bitcnt < 11, the frame is rejected: frame_err pulses, and no latch or register changes.
  - In both cases bitcnt clears to 0. shift is not cleared.
- On each ldac falling edge, all four out_reg <= in_latch, and upd pulses.
- If an ldac falling edge and an accepted load falling edge occur in the same cycle:
  - The latch write happens first, so out_reg[A] takes the new value and the other channels take their existing latches.
  - upd pulses once.
- A load rising edge has no effect beyond re-enabling shifting.
- ch_a..ch_d and rng are direct register outputs of out_reg, with no combinational path from the inputs.
- Reset (asynchronous, any time, including mid-frame):
  - All latches, out_reg, rng, bitcnt, shift and last_addr go to 0.
  - All pulse outputs go to 0.
  - A partially received frame is discarded.

## Timing
- Input requirement: each level of dac_clk, load and ldac is held for at least SYNC_STAGES+1 clk cycles. data is stable from SYNC_STAGES+1 cycles before a dac_clk falling edge until SYNC_STAGES+1 cycles after it.
- Latency from a pin edge to the registered effect:
  - SYNC_STAGES+1 clk rising edges to detection.
  - The effect is visible after the next rising edge, so the total is SYNC_STAGES+2 edges (4 with the default).
- frame_ok and frame_err are mutually exclusive and each lasts exactly one cycle.
- upd is high for exactly one cycle per write event.
- Throughput: back-to-back frames with no idle dac_clk periods are accepted. Only the load-high gap is required between frames.

## Test plan
- Reset: hold rst=0 with the pins at dac_clk=1, load=0, ldac=0, then release. Required: all outputs 0, no pulses, and bitcnt=0 (confirmed by sending a 10-bit frame, which must raise frame_err).
- Latched update: with ldac=1, send frame 10_1_0x5A and pulse load. Required: frame_ok, last_addr=2, ch_c still 0, no upd. Then pulse ldac. Required: ch_c=0x5A, rng=4'b0100, upd for one cycle, 4 clk cycles after the ldac pin falls.
- Immediate update: with ldac held 0, send 01_0_0xC3 and pulse load. Required: ch_b=0xC3, rng[1]=0, upd and frame_ok in the same cycle.
- Short and long frames: send 9 bits then load low. Required: frame_err, no state change. Send 13 bits ending in 00_1_0xFF. Required: frame_ok, ch_a latch=0xFF.
- Simultaneous edges: latches hold A=0x11, B=0x22. Make the load and ldac pins fall on the same clk edge with a frame 00_0_0x77. Required: ch_a=0x77, ch_b=0x22, a single upd pulse.
- Reset mid-frame: assert rst after 6 bits, release, then send a full frame 11_0_0x81 with ldac=0. Required: ch_d=0x81, frame_ok, no frame_err.
